// File: rtl/maxpool2x2_relu.sv
// Streaming 2x2 stride-2 max-pool with optional ReLU over a raster-order feature map.
// Horizontal pairs reduce in a pair register; even-row pair maxima wait in a half-width line buffer.
module maxpool2x2_relu #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IMG_W      = 24,
  parameter int unsigned IMG_H      = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  relu_en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned ColW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RowW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned LbD  = IMG_W / 2;
  localparam int unsigned LbW  = (LbD > 1) ? $clog2(LbD) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e state_q, state_d;

  logic [ColW-1:0]              col_q;
  logic [RowW-1:0]              row_q;
  logic                         relu_q;
  logic signed [DATA_WIDTH-1:0] pair_q;
  logic signed [DATA_WIDTH-1:0] linebuf_q [LbD];

  logic signed [DATA_WIDTH-1:0] pix;
  logic signed [DATA_WIDTH-1:0] pmax;
  logic signed [DATA_WIDTH-1:0] lb_rd;
  logic signed [DATA_WIDTH-1:0] win_max;
  logic signed [DATA_WIDTH-1:0] result;
  logic [LbW-1:0]               lb_idx;
  logic                         in_fire;
  logic                         out_fire;
  logic                         last_col;
  logic                         last_row;

  assign in_ready = (state_q == StRun) && (!out_valid || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign busy     = (state_q == StRun) || (state_q == StDrain);
  assign done     = (state_q == StDone);

  assign last_col = (col_q == ColW'(IMG_W - 1));
  assign last_row = (row_q == RowW'(IMG_H - 1));
  assign lb_idx   = LbW'(col_q >> 1);

  // Window reduction: horizontal pair first, then against the stored upper-row pair.
  assign pix     = $signed(in_data);
  assign pmax    = (pix > pair_q) ? pix : pair_q;
  assign lb_rd   = linebuf_q[lb_idx];
  assign win_max = (pmax > lb_rd) ? pmax : lb_rd;
  assign result  = (relu_q && win_max[DATA_WIDTH-1]) ? '0 : win_max;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (in_fire && last_col && last_row) state_d = StDrain;
      StDrain: if (out_fire) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      col_q     <= '0;
      row_q     <= '0;
      relu_q    <= 1'b0;
      pair_q    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && start) begin
        relu_q <= relu_en;
        col_q  <= '0;
        row_q  <= '0;
      end
      if (in_fire) begin
        if (!col_q[0]) pair_q <= pix;
        if (last_col) begin
          col_q <= '0;
          row_q <= last_row ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
      // A new result may replace one being accepted in the same cycle.
      if (in_fire && col_q[0] && row_q[0]) begin
        out_valid <= 1'b1;
        out_data  <= result;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire && col_q[0] && !row_q[0]) linebuf_q[lb_idx] <= pmax;
  end

endmodule

// File: tb/tb_maxpool2x2_relu.sv
// Directed table-driven bench on a 4x4 instance plus a random 24x24 frame against a model.
module tb_maxpool2x2_relu;

  typedef struct packed {
    logic            relu;
    logic [15:0][7:0] pix;
    logic [3:0][7:0]  exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, relu_en, in_valid, in_ready, out_valid, out_ready, busy, done;
  logic [7:0] in_data, out_data;
  logic       b_start, b_relu, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy, b_done;
  logic [7:0] b_in_data, b_out_data;

  int   n_vec = 0;
  int   n_err = 0;
  vec_t vecs[6];
  int   p[16];
  int   e[4];

  always #5 clk = ~clk;

  maxpool2x2_relu #(.DATA_WIDTH(8), .IMG_W(4), .IMG_H(4)) dut (
    .clk(clk), .rst(rst), .start(start), .relu_en(relu_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done)
  );

  maxpool2x2_relu dut24 (
    .clk(clk), .rst(rst), .start(b_start), .relu_en(b_relu),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .busy(b_busy), .done(b_done)
  );

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic pack_vec(input int k, input logic r);
    vecs[k].relu = r;
    for (int i = 0; i < 16; i++) vecs[k].pix[i] = 8'(p[i]);
    for (int i = 0; i < 4; i++) vecs[k].exp[i] = 8'(e[i]);
  endtask

  // mode 0: out_ready=1; mode 1: random backpressure; mode 2: start re-pulsed mid-frame
  task automatic run_frame(input vec_t v, input int mode, input string name);
    int         in_idx = 0;
    int         out_idx = 0;
    int         cyc = 0;
    int         last_acc = -10;
    logic       hold_v = 1'b0;
    logic [7:0] hold_d = '0;
    in_valid = 1'b1; in_data = 8'd99; out_ready = 1'b1; start = 1'b0;
    repeat (2) begin
      @(negedge clk); #1;
      check({name, " idle in_ready"}, in_ready, 0);
    end
    relu_en = v.relu; start = 1'b1;
    while (cyc < 300) begin
      @(negedge clk); cyc++;
      if (done) break;
      if (cyc == 1) check({name, " busy after start"}, busy, 1);
      in_valid  = (in_idx < 16);
      in_data   = (in_idx < 16) ? v.pix[in_idx] : 8'h00;
      out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      start     = (mode == 2 && in_idx >= 6 && in_idx <= 9);
      #1;
      if (hold_v) begin
        check({name, " hold valid"}, out_valid, 1);
        check({name, " hold data"}, $signed(out_data), $signed(hold_d));
      end
      if (out_valid && !out_ready) check({name, " in_ready stall"}, in_ready, 0);
      if (in_idx == 16) check({name, " in_ready drain"}, in_ready, 0);
      if (out_valid && out_ready) begin
        if (out_idx < 4) check({name, " out"}, $signed(out_data), $signed(v.exp[out_idx]));
        else check({name, " extra output"}, out_idx, 3);
        out_idx++;
        last_acc = cyc;
      end
      hold_v = out_valid && !out_ready;
      hold_d = out_data;
      if (in_valid && in_ready) in_idx++;
    end
    in_valid = 1'b0; start = 1'b0;
    check({name, " done seen"}, done, 1);
    check({name, " done latency"}, cyc - last_acc, 1);
    check({name, " busy at done"}, busy, 0);
    check({name, " output count"}, out_idx, 4);
    check({name, " input count"}, in_idx, 16);
    @(negedge clk); #1;
    check({name, " done single"}, done, 0);
    check({name, " busy after done"}, busy, 0);
  endtask

  task automatic reset_checks(input string name);
    check({name, " in_ready"}, in_ready, 0);
    check({name, " out_valid"}, out_valid, 0);
    check({name, " out_data"}, out_data, 0);
    check({name, " busy"}, busy, 0);
    check({name, " done"}, done, 0);
  endtask

  task automatic run_big();
    int img[576];
    int exp_q[$];
    int outs = 0;
    int idx = 0;
    int dones = 0;
    int cyc = 0;
    for (int i = 0; i < 576; i++) img[i] = int'($urandom_range(0, 255)) - 128;
    for (int r = 0; r < 24; r += 2) begin
      for (int c = 0; c < 24; c += 2) begin
        int m;
        m = img[r*24+c];
        if (img[r*24+c+1] > m) m = img[r*24+c+1];
        if (img[(r+1)*24+c] > m) m = img[(r+1)*24+c];
        if (img[(r+1)*24+c+1] > m) m = img[(r+1)*24+c+1];
        exp_q.push_back((m < 0) ? 0 : m);
      end
    end
    @(negedge clk); b_relu = 1'b1; b_start = 1'b1;
    @(negedge clk); b_start = 1'b0;
    while (cyc < 5000 && dones == 0) begin
      b_in_valid  = (idx < 576) && ($urandom_range(0, 3) != 0);
      b_in_data   = (idx < 576) ? 8'(img[idx]) : 8'h00;
      b_out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (b_out_valid && b_out_ready) begin
        if (exp_q.size() > 0) check("big out", $signed(b_out_data), exp_q.pop_front());
        else check("big extra output", outs, 143);
        check("big non-negative", b_out_data[7], 0);
        outs++;
      end
      if (b_in_valid && b_in_ready) idx++;
      @(negedge clk); cyc++;
      if (b_done) dones++;
    end
    b_in_valid = 1'b0;
    check("big outputs", outs, 144);
    repeat (4) begin
      @(negedge clk);
      if (b_done) dones++;
    end
    check("big done pulses", dones, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; relu_en = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    b_start = 1'b0; b_relu = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;

    p = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
    e = '{5, 7, 13, 15};
    pack_vec(0, 1'b0);
    p = '{-3, -1, -5, 4, -8, -2, -7, -128, -128, -128, 10, 10, -128, -128, 10, 10};
    e = '{0, 4, 0, 10};
    pack_vec(1, 1'b1);
    e = '{-1, 4, -128, 10};
    pack_vec(2, 1'b0);
    p = '{127, -128, 3, 3, -128, -128, 2, 5, 0, -1, -50, -60, -2, 1, -70, -40};
    e = '{127, 5, 1, -40};
    pack_vec(3, 1'b0);
    e = '{127, 5, 1, 0};
    pack_vec(4, 1'b1);
    pack_vec(5, 1'b0);

    repeat (3) @(negedge clk);
    #1 reset_checks("reset");
    rst = 1'b0;

    for (int k = 0; k < 5; k++) run_frame(vecs[k], 0, $sformatf("vec%0d", k));
    run_frame(vecs[0], 1, "backpressure ramp");
    run_frame(vecs[3], 1, "backpressure mixed");
    run_frame(vecs[2], 2, "start re-pulse");

    // Abort a frame after six inputs, then run a clean frame.
    begin
      int acc = 0;
      int cyc = 0;
      @(negedge clk); relu_en = 1'b0; start = 1'b1; out_ready = 1'b1;
      @(negedge clk); start = 1'b0;
      while (acc < 6 && cyc < 50) begin
        in_valid = 1'b1; in_data = vecs[0].pix[acc];
        #1;
        if (in_ready) acc++;
        @(negedge clk); cyc++;
      end
      in_valid = 1'b0;
      check("abort inputs", acc, 6);
      check("abort pending out", $signed(out_data), 5);
      rst = 1'b1;
      @(negedge clk); rst = 1'b0; #1;
      reset_checks("mid-frame reset");
      repeat (3) begin
        @(negedge clk); #1;
        check("no done after abort", done, 0);
      end
    end
    run_frame(vecs[0], 0, "after reset");

    run_big();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
